// File: rtl/elevator_run_monitor_if.sv
// ---------------------------------------------------------------------------
// elevator_run_monitor_if
//   Bundles the registered elevator state consumed by elevator_run_monitor
//   and the status/display signals it produces.
//   master : upstream/observer side (drives the elevator state, reads status)
//   slave  : the monitor itself
//   Signals:
//     remaining_1..7   6b  waiting count per floor
//     boarding_1,_2    6b  riding count per car
//     curr_elevator_*  3b  floor of each car
//     done, timeout    1b  run status
//     step_count       STEP_W  steps taken while running
//     total_waiting    9b, total_riding 7b  registered sums
//     digit_sel        4b one-hot digit enable, digit_val 4b hex nibble
// ---------------------------------------------------------------------------
interface elevator_run_monitor_if #(
  parameter int STEP_W = 10
);
  logic [5:0]        remaining_1;
  logic [5:0]        remaining_2;
  logic [5:0]        remaining_3;
  logic [5:0]        remaining_4;
  logic [5:0]        remaining_5;
  logic [5:0]        remaining_6;
  logic [5:0]        remaining_7;
  logic [5:0]        boarding_1;
  logic [5:0]        boarding_2;
  logic [2:0]        curr_elevator_1;
  logic [2:0]        curr_elevator_2;
  logic              done;
  logic              timeout;
  logic [STEP_W-1:0] step_count;
  logic [8:0]        total_waiting;
  logic [6:0]        total_riding;
  logic [3:0]        digit_sel;
  logic [3:0]        digit_val;

  modport master (
    output remaining_1, remaining_2, remaining_3, remaining_4,
           remaining_5, remaining_6, remaining_7,
           boarding_1, boarding_2, curr_elevator_1, curr_elevator_2,
    input  done, timeout, step_count, total_waiting, total_riding,
           digit_sel, digit_val
  );

  modport slave (
    input  remaining_1, remaining_2, remaining_3, remaining_4,
           remaining_5, remaining_6, remaining_7,
           boarding_1, boarding_2, curr_elevator_1, curr_elevator_2,
    output done, timeout, step_count, total_waiting, total_riding,
           digit_sel, digit_val
  );
endinterface

// File: rtl/elevator_run_monitor.sv
// ---------------------------------------------------------------------------
// elevator_run_monitor
//   Counts simulation steps (one per clock edge) until every floor and car
//   is empty, then holds done until reset. Publishes registered passenger
//   totals and scans car floors / step count onto a 4-digit hex display.
//   Optional macro RUN_TIMEOUT_EN adds a TIMEOUT terminal state entered when
//   step_count reaches TIMEOUT_STEPS while passengers remain.
//   Ports:
//     clock        rising-edge clock
//     reset_start  asynchronous active-high reset
//     bus          elevator_run_monitor_if.slave (state in, status/display out)
// ---------------------------------------------------------------------------
module elevator_run_monitor #(
  parameter int STEP_W        = 10,
  parameter int SCAN_DIV      = 16,
  parameter int TIMEOUT_STEPS = 500
) (
  input  logic                  clock,
  input  logic                  reset_start,
  elevator_run_monitor_if.slave bus
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam bit PARAMS_OK = (SCAN_DIV >= 2) && (TIMEOUT_STEPS >= 0) &&
                             (TIMEOUT_STEPS < (2 ** STEP_W));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("elevator_run_monitor: SCAN_DIV must be >=2 and TIMEOUT_STEPS < 2**STEP_W");
    end
  endgenerate

`ifdef RUN_TIMEOUT_EN
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DONE = 2'd1, ST_TIMEOUT = 2'd2} state_t;
  localparam logic [STEP_W-1:0] TIMEOUT_LIMIT = STEP_W'(TIMEOUT_STEPS);
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DONE = 2'd1} state_t;
`endif

  state_t            state, state_next;
  logic [STEP_W-1:0] step_count, step_next;
  logic              empty;
  logic [8:0]        total_waiting;
  logic [6:0]        total_riding;
  logic [SCAN_W-1:0] scan_cnt;
  logic [3:0]        digit_sel, sel_next;
  logic [3:0]        digit_val, val_next;
  logic [7:0]        step_lo8;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + STEP_W'(1);
  endfunction

  assign empty = (bus.remaining_1 == 6'd0) && (bus.remaining_2 == 6'd0) &&
                 (bus.remaining_3 == 6'd0) && (bus.remaining_4 == 6'd0) &&
                 (bus.remaining_5 == 6'd0) && (bus.remaining_6 == 6'd0) &&
                 (bus.remaining_7 == 6'd0) &&
                 (bus.boarding_1 == 6'd0) && (bus.boarding_2 == 6'd0);

  // ---- run FSM: next state and step counter ----
  always_comb begin
    state_next = state;
    step_next  = step_count;
    case (state)
      ST_RUN: begin
        // Empty takes priority over the step limit on the same edge.
        if (empty) begin
          state_next = ST_DONE;
`ifdef RUN_TIMEOUT_EN
        end else if (step_count == TIMEOUT_LIMIT) begin
          state_next = ST_TIMEOUT;
`endif
        end else begin
          step_next = sat_inc(step_count);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset_start) begin
    if (reset_start) begin
      state      <= ST_RUN;
      step_count <= '0;
    end else begin
      state      <= state_next;
      step_count <= step_next;
    end
  end

  // ---- totals: one-cycle registered sums, updated in every state ----
  always_ff @(posedge clock or posedge reset_start) begin
    if (reset_start) begin
      total_waiting <= '0;
      total_riding  <= '0;
    end else begin
      total_waiting <= 9'(bus.remaining_1) + 9'(bus.remaining_2) +
                       9'(bus.remaining_3) + 9'(bus.remaining_4) +
                       9'(bus.remaining_5) + 9'(bus.remaining_6) +
                       9'(bus.remaining_7);
      total_riding  <= 7'(bus.boarding_1) + 7'(bus.boarding_2);
    end
  end

  // ---- display scan ----
  generate
    if (STEP_W >= 8) begin : g_step_wide
      assign step_lo8 = step_count[7:0];
    end else begin : g_step_narrow
      assign step_lo8 = 8'(step_count);
    end
  endgenerate

  // digit_val is loaded from the digit that digit_sel will show after this
  // edge, so the pair never disagrees; contents refresh every clock.
  always_comb begin
    sel_next = (scan_cnt == SCAN_LAST) ? {digit_sel[2:0], digit_sel[3]} : digit_sel;
    val_next = 4'd0;
    case (sel_next)
      4'b0001: val_next = {1'b0, bus.curr_elevator_1};
      4'b0010: val_next = {1'b0, bus.curr_elevator_2};
      4'b0100: val_next = step_lo8[3:0];
      4'b1000: val_next = step_lo8[7:4];
      default: val_next = 4'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset_start) begin
    if (reset_start) begin
      scan_cnt  <= '0;
      digit_sel <= 4'b0001;
      digit_val <= 4'd0;
    end else begin
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_W'(1);
      digit_sel <= sel_next;
      digit_val <= val_next;
    end
  end

  assign bus.done          = (state == ST_DONE);
`ifdef RUN_TIMEOUT_EN
  assign bus.timeout       = (state == ST_TIMEOUT);
`else
  assign bus.timeout       = 1'b0;
`endif
  assign bus.step_count    = step_count;
  assign bus.total_waiting = total_waiting;
  assign bus.total_riding  = total_riding;
  assign bus.digit_sel     = digit_sel;
  assign bus.digit_val     = digit_val;

endmodule
